// File: rtl/ctrl_pipeline_pkg.sv
// Shared definitions for the ID/EX/MEM/WB control pipeline.
// Holds the forwarding-select codes, the bubble field values and the default widths.
// No logic; imported by the interface, the forwarding unit and the top.
package ctrl_pipeline_pkg;

    // Default widths; the top and the interface take these as parameter defaults.
    localparam int REG_AW_DEF  = 5;
    localparam int ALUOP_W_DEF = 3;

    // EX operand source selects. The MEM/WB code is 01 and the EX/MEM code is 10,
    // so the two bits directly steer the operand muxes in EX.
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_EXMEM   = 2'b10,
        FWD_MEMWB   = 2'b01
    } fwd_sel_e;

    // Bubble contents: every control/valid bit low and every register index zero.
    localparam logic        CTRL_BUBBLE_BIT = 1'b0;
    localparam int unsigned CTRL_BUBBLE_IDX = 0;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Handshake/bus bundle between the ID stage, EX redirect source and the control pipeline.
// master: drives the decoder bundle and ex_redirect, observes enables, stage contents, forward selects.
// slave : the pipeline itself (receives the bundle, drives everything else).
interface ctrl_pipeline_if
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF
);
    // ID-stage decoder bundle
    logic               id_valid;
    logic               id_branch;
    logic               id_MemRead;
    logic               id_MemtoReg;
    logic               id_MemWrite;
    logic               id_ALUSrc1;
    logic               id_ALUSrc2;
    logic               id_RegWrite;
    logic               id_jump;
    logic [ALUOP_W-1:0] id_ALUOp;
    logic [REG_AW-1:0]  id_rs1;
    logic [REG_AW-1:0]  id_rs2;
    logic [REG_AW-1:0]  id_rd;
    logic               ex_redirect;

    // Front-end enables
    logic               pc_write;
    logic               ifid_write;
    logic               ifid_flush;

    // ID/EX contents
    logic               ex_valid;
    logic               ex_branch;
    logic               ex_jump;
    logic               ex_ALUSrc1;
    logic               ex_ALUSrc2;
    logic               ex_MemRead;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic [REG_AW-1:0]  ex_rs1;
    logic [REG_AW-1:0]  ex_rs2;

    // EX/MEM and MEM/WB contents
    logic               mem_valid;
    logic               mem_MemRead;
    logic               mem_MemWrite;
    logic [REG_AW-1:0]  mem_rd;
    logic               wb_valid;
    logic               wb_RegWrite;
    logic               wb_MemtoReg;
    logic [REG_AW-1:0]  wb_rd;

    // EX operand forwarding selects
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;

    modport master (
        output id_valid, id_branch, id_MemRead, id_MemtoReg, id_MemWrite,
               id_ALUSrc1, id_ALUSrc2, id_RegWrite, id_jump, id_ALUOp,
               id_rs1, id_rs2, id_rd, ex_redirect,
        input  pc_write, ifid_write, ifid_flush,
               ex_valid, ex_branch, ex_jump, ex_ALUSrc1, ex_ALUSrc2, ex_MemRead,
               ex_ALUOp, ex_rs1, ex_rs2,
               mem_valid, mem_MemRead, mem_MemWrite, mem_rd,
               wb_valid, wb_RegWrite, wb_MemtoReg, wb_rd,
               fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_branch, id_MemRead, id_MemtoReg, id_MemWrite,
               id_ALUSrc1, id_ALUSrc2, id_RegWrite, id_jump, id_ALUOp,
               id_rs1, id_rs2, id_rd, ex_redirect,
        output pc_write, ifid_write, ifid_flush,
               ex_valid, ex_branch, ex_jump, ex_ALUSrc1, ex_ALUSrc2, ex_MemRead,
               ex_ALUOp, ex_rs1, ex_rs2,
               mem_valid, mem_MemRead, mem_MemWrite, mem_rd,
               wb_valid, wb_RegWrite, wb_MemtoReg, wb_rd,
               fwd_a, fwd_b
    );

endinterface

// File: rtl/ctrl_pipeline_forwarding_unit.sv
// Forwarding select for one EX source operand; EX/MEM beats MEM/WB, x0 is never forwarded.
// Latency: purely combinational.
// Backpressure: none.
// Ports: ex_src (EX source index), mem_reg_write/mem_rd, wb_reg_write/wb_rd (later-stage writers),
//        sel (FWD_REGFILE / FWD_EXMEM / FWD_MEMWB).
module ctrl_pipeline_forwarding_unit
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] ex_src,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    output fwd_sel_e          sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_src);
    assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_src);

    always_comb begin
        sel = FWD_REGFILE;
        // The younger result (EX/MEM) is the architecturally correct one when both match.
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries the decoder control bundle through ID/EX, EX/MEM, MEM/WB; load-use stall, redirect flush, forwarding.
// Latency: ID bundle on ex_* after 1 clk, mem_* after 2, wb_* after 3; hazard/forward outputs combinational.
// Backpressure: only the 1-cycle load-use stall (pc_write/ifid_write low); EX/MEM and MEM/WB always advance.
// Ports: clk, rst (async, active-high), bus (ctrl_pipeline_if.slave: ID bundle + ex_redirect in,
//        pc_write/ifid_write/ifid_flush, ex_*/mem_*/wb_* stage contents and fwd_a/fwd_b out).
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    ctrl_pipeline_if.slave bus
);

    typedef struct packed {
        logic               valid;
        logic               branch;
        logic               jump;
        logic               mem_read;
        logic               mem_to_reg;
        logic               mem_write;
        logic               alu_src1;
        logic               alu_src2;
        logic               reg_write;
        logic [ALUOP_W-1:0] alu_op;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [REG_AW-1:0]  rd;
    } idex_t;

    typedef struct packed {
        logic              valid;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic              valid;
        logic              mem_to_reg;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
    } memwb_t;

    localparam idex_t IDEX_BUBBLE = '{
        valid:      CTRL_BUBBLE_BIT,
        branch:     CTRL_BUBBLE_BIT,
        jump:       CTRL_BUBBLE_BIT,
        mem_read:   CTRL_BUBBLE_BIT,
        mem_to_reg: CTRL_BUBBLE_BIT,
        mem_write:  CTRL_BUBBLE_BIT,
        alu_src1:   CTRL_BUBBLE_BIT,
        alu_src2:   CTRL_BUBBLE_BIT,
        reg_write:  CTRL_BUBBLE_BIT,
        alu_op:     ALUOP_W'(CTRL_BUBBLE_IDX),
        rs1:        REG_AW'(CTRL_BUBBLE_IDX),
        rs2:        REG_AW'(CTRL_BUBBLE_IDX),
        rd:         REG_AW'(CTRL_BUBBLE_IDX)
    };

    localparam exmem_t EXMEM_BUBBLE = '{
        valid:      CTRL_BUBBLE_BIT,
        mem_read:   CTRL_BUBBLE_BIT,
        mem_write:  CTRL_BUBBLE_BIT,
        mem_to_reg: CTRL_BUBBLE_BIT,
        reg_write:  CTRL_BUBBLE_BIT,
        rd:         REG_AW'(CTRL_BUBBLE_IDX)
    };

    localparam memwb_t MEMWB_BUBBLE = '{
        valid:      CTRL_BUBBLE_BIT,
        mem_to_reg: CTRL_BUBBLE_BIT,
        reg_write:  CTRL_BUBBLE_BIT,
        rd:         REG_AW'(CTRL_BUBBLE_IDX)
    };

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic     redirect;
    logic     load_use;
    logic     rd_matches_src;
    fwd_sel_e fwd_a_sel;
    fwd_sel_e fwd_b_sel;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // Redirect is masked during reset so the front end sees a clean
    // "run, no flush" while the pipeline is being cleared.
    assign redirect = bus.ex_redirect & ~rst;

    // rs2 is compared even for formats that do not read it; an occasional
    // spurious stall is cheaper than decoding the format here.
    assign rd_matches_src = (idex_q.rd == bus.id_rs1) || (idex_q.rd == bus.id_rs2);
    assign load_use = idex_q.valid && idex_q.mem_read && bus.id_valid &&
                      (idex_q.rd != '0) && rd_matches_src;

    // Redirect overrides the stall: the stalled instruction is on the wrong
    // path anyway, so the front end must move to the target.
    assign bus.pc_write   = redirect | ~load_use;
    assign bus.ifid_write = redirect | ~load_use;
    assign bus.ifid_flush = redirect;

    // ------------------------------------------------------------------
    // Next-state for the stage registers
    // ------------------------------------------------------------------
    always_comb begin
        idex_d = IDEX_BUBBLE;
        // An invalid ID slot is also loaded as a bubble so that no stray
        // control bit can ride along with valid=0.
        if (!redirect && !load_use && bus.id_valid) begin
            idex_d.valid      = 1'b1;
            idex_d.branch     = bus.id_branch;
            idex_d.jump       = bus.id_jump;
            idex_d.mem_read   = bus.id_MemRead;
            idex_d.mem_to_reg = bus.id_MemtoReg;
            idex_d.mem_write  = bus.id_MemWrite;
            idex_d.alu_src1   = bus.id_ALUSrc1;
            idex_d.alu_src2   = bus.id_ALUSrc2;
            idex_d.reg_write  = bus.id_RegWrite;
            idex_d.alu_op     = bus.id_ALUOp;
            idex_d.rs1        = bus.id_rs1;
            idex_d.rs2        = bus.id_rs2;
            idex_d.rd         = bus.id_rd;
        end
    end

    // The EX instruction always advances, including the redirecting one.
    always_comb begin
        exmem_d            = EXMEM_BUBBLE;
        exmem_d.valid      = idex_q.valid;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.rd         = idex_q.rd;
    end

    always_comb begin
        memwb_d            = MEMWB_BUBBLE;
        memwb_d.valid      = exmem_q.valid;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.rd         = exmem_q.rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q  <= IDEX_BUBBLE;
            exmem_q <= EXMEM_BUBBLE;
            memwb_q <= MEMWB_BUBBLE;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    ctrl_pipeline_forwarding_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_rs1 (
        .ex_src        (idex_q.rs1),
        .mem_reg_write (exmem_q.reg_write),
        .mem_rd        (exmem_q.rd),
        .wb_reg_write  (memwb_q.reg_write),
        .wb_rd         (memwb_q.rd),
        .sel           (fwd_a_sel)
    );

    ctrl_pipeline_forwarding_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_rs2 (
        .ex_src        (idex_q.rs2),
        .mem_reg_write (exmem_q.reg_write),
        .mem_rd        (exmem_q.rd),
        .wb_reg_write  (memwb_q.reg_write),
        .wb_rd         (memwb_q.rd),
        .sel           (fwd_b_sel)
    );

    assign bus.fwd_a = fwd_a_sel;
    assign bus.fwd_b = fwd_b_sel;

    // ------------------------------------------------------------------
    // Stage contents visible to the datapath
    // ------------------------------------------------------------------
    assign bus.ex_valid     = idex_q.valid;
    assign bus.ex_branch    = idex_q.branch;
    assign bus.ex_jump      = idex_q.jump;
    assign bus.ex_ALUSrc1   = idex_q.alu_src1;
    assign bus.ex_ALUSrc2   = idex_q.alu_src2;
    assign bus.ex_MemRead   = idex_q.mem_read;
    assign bus.ex_ALUOp     = idex_q.alu_op;
    assign bus.ex_rs1       = idex_q.rs1;
    assign bus.ex_rs2       = idex_q.rs2;

    assign bus.mem_valid    = exmem_q.valid;
    assign bus.mem_MemRead  = exmem_q.mem_read;
    assign bus.mem_MemWrite = exmem_q.mem_write;
    assign bus.mem_rd       = exmem_q.rd;

    assign bus.wb_valid     = memwb_q.valid;
    assign bus.wb_RegWrite  = memwb_q.reg_write;
    assign bus.wb_MemtoReg  = memwb_q.mem_to_reg;
    assign bus.wb_rd        = memwb_q.rd;

endmodule
